// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic DEPTH-slot pipeline register with valid/ready, flush and occupancy
// Optional input skid entry enabled by defining PIPE_STAGE_BUF_SKID_EN.
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             accept;
    logic             pop;

    // Ready ripples from the head back to slot 0 so bubbles collapse under stall.
    always_comb begin
        logic r;
        rdy = '0;
        r = !v[DEPTH-1] | out_ready;
        rdy[DEPTH-1] = r;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            r = !v[i] | r;
            rdy[i] = r;
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // in_ready comes straight from a flop, cutting the out_ready->in_ready path.
    assign in_ready  = !skid_valid;
    assign src_valid = skid_valid | in_valid;
    assign src_data  = skid_valid ? skid_data : in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (rdy[0]) skid_valid <= 1'b0;
        end else if (in_valid && !rdy[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready  = rdy[0];
    assign src_valid = in_valid;
    assign src_data  = in_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) d[i] <= d[i-1];
                end
            end
            if (rdy[0]) begin
                v[0] <= src_valid;
                if (src_valid) d[0] <= src_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (accept && !pop) begin
            occupancy <= occupancy + CNT_ONE;
        end else if (pop && !accept) begin
            occupancy <= occupancy - CNT_ONE;
        end
    end

endmodule
